// File: rtl/midi_tx.sv
// midi_tx: serializes one MIDI message (status + two data bytes) per
// valid/ready handshake into an 8N1 UART stream on tx.
// Optional feature macro: MIDI_TX_RUNNING_STATUS_EN. When it is defined, the
// status byte is omitted if it matches the previous status sent.
//
// state | meaning
// IDLE  | waiting for message_valid; message_ready high, tx at mark
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx=1); then next byte's START or back to IDLE
module midi_tx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 31_250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] message,
  input  logic [3:0]  channel,
  input  logic        message_valid,
  output logic        message_ready,
  output logic        tx,
  output logic        busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_cfg_check
    $error("midi_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte1_q, byte1_d;
  logic [7:0]    byte2_q, byte2_d;
  logic          tx_q, tx_d;
  logic [7:0]    byte0;
  logic          skip_status;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0]    last_status_q, last_status_d;
  logic          rs_valid_q, rs_valid_d;
`endif

  // Next-state and datapath: one down-counter times every bit period.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    byte1_d     = byte1_q;
    byte2_d     = byte2_q;
    tx_d        = tx_q;
    byte0       = {message[17:14], channel};
    skip_status = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    last_status_d = last_status_q;
    rs_valid_d    = rs_valid_q;
    skip_status   = rs_valid_q && (byte0 == last_status_q);
`endif

    case (state_q)
      IDLE: begin
        if (message_valid) begin
          state_d   = START;
          tx_d      = 1'b0;
          cnt_d     = BIT_LAST;
          bit_idx_d = 3'd0;
          byte1_d   = {1'b0, message[13:7]};
          byte2_d   = {1'b0, message[6:0]};
          if (skip_status) begin
            // Status repeats: start directly at data byte 1.
            shift_d    = {1'b0, message[13:7]};
            byte_idx_d = 2'd1;
          end else begin
            shift_d    = byte0;
            byte_idx_d = 2'd0;
          end
`ifdef MIDI_TX_RUNNING_STATUS_EN
          // Safe to record at accept: a reset before the frame ends clears the flag.
          last_status_d = byte0;
          rs_valid_d    = 1'b1;
`endif
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          cnt_d     = BIT_LAST;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (byte_idx_q < 2'd2) begin
            state_d    = START;
            tx_d       = 1'b0;
            cnt_d      = BIT_LAST;
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = (byte_idx_q == 2'd0) ? byte1_q : byte2_q;
          end else begin
            state_d    = IDLE;
            byte_idx_d = 2'd0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      bit_idx_q  <= 3'd0;
      cnt_q      <= '0;
      shift_q    <= 8'd0;
      byte1_q    <= 8'd0;
      byte2_q    <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      byte1_q    <= byte1_d;
      byte2_q    <= byte2_d;
      tx_q       <= tx_d;
    end
  end

`ifdef MIDI_TX_RUNNING_STATUS_EN
  // Running-status memory of the last status byte put on the wire.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_status_q <= 8'd0;
      rs_valid_q    <= 1'b0;
    end else begin
      last_status_q <= last_status_d;
      rs_valid_q    <= rs_valid_d;
    end
  end
`endif

  assign tx            = tx_q;
  assign message_ready = (state_q == IDLE);
  assign busy          = ~message_ready;

endmodule

// File: tb/tb_midi_tx.sv
// Testbench for midi_tx: random and directed messages, a UART-decoding
// monitor and an expected-byte scoreboard.
module tb_midi_tx;

  localparam int CLK_FREQ = 312_500;
  localparam int BAUD     = 31_250;
  localparam int C        = CLK_FREQ / BAUD;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] message;
  logic [3:0]  channel;
  logic        message_valid;
  logic        message_ready;
  logic        tx;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          rst_count = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  exp_q[$];
  bit          rs_valid = 1'b0;
  logic [7:0]  last_status = 8'd0;

  midi_tx #(.CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clock(clk), .reset(reset), .message(message), .channel(channel),
    .message_valid(message_valid), .message_ready(message_ready),
    .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_count <= rst_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decode UART bytes at mid-bit and compare with the scoreboard.
  initial begin : monitor
    logic       prev;
    logic [7:0] data;
    logic       start_b;
    logic       stop_b;
    int         rc;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx) begin
        rc = rst_count;
        repeat (C / 2) @(negedge clk);
        start_b = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          data[i] = tx;
        end
        repeat (C) @(negedge clk);
        stop_b = tx;
        if (rc == rst_count) begin
          check("start_bit", 32'(start_b), 32'd0);
          check("stop_bit", 32'(stop_b), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", data);
          end else begin
            check("rx_byte", 32'(data), 32'(exp_q.pop_front()));
          end
        end
      end
      prev = tx;
    end
  end

  // Present a message, wait for acceptance, record the expected bytes.
  task automatic issue(input logic [3:0] mt, input logic [3:0] ch, input logic [6:0] d1,
                       input logic [6:0] d2, input bit hold, output int nb, output int fall);
    int n;
    logic [7:0] b0;
    message       = {mt, d1, d2};
    channel       = ch;
    message_valid = 1'b1;
    n = 0;
    while (!message_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!message_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: ready still 0 after %0d cycles", n);
      message_valid = 1'b0;
      nb   = 0;
      fall = cyc;
      return;
    end
    b0 = {mt, ch};
    if (RS && rs_valid && b0 == last_status) nb = 2;
    else begin
      nb = 3;
      exp_q.push_back(b0);
    end
    exp_q.push_back({1'b0, d1});
    exp_q.push_back({1'b0, d2});
    last_status = b0;
    rs_valid    = 1'b1;
    @(negedge clk);
    fall = cyc;
    check("tx_fall_latency", 32'(tx), 32'd0);
    check("ready_low_after_accept", 32'(message_ready), 32'd0);
    check("busy_high", 32'(busy), 32'd1);
    if (!hold) message_valid = 1'b0;
  endtask

  // Wait for message_ready; frame must last nb*10*C cycles from tx fall.
  task automatic wait_ready(input int nb, input int elapsed);
    int cnt;
    cnt = elapsed;
    while (!message_ready && cnt < nb * 10 * C + 50) begin
      @(negedge clk);
      cnt++;
    end
    check("frame_len", 32'(cnt), 32'(nb * 10 * C));
    check("busy_low_idle", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nb, nb1, nb2, f1, f2, changes;
    int prev_nb, prev_fall;
    bit prev_hold, hold;
    logic [3:0] mt, ch;

    reset = 1'b1;
    message_valid = 1'b0;
    message = '0;
    channel = '0;

    // Reset held 3 cycles.
    repeat (3) begin
      @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_ready", 32'(message_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) changes++;
    end
    check("idle_no_tx_edge", 32'(changes), 32'd0);

    // Control change ch0: 0xB0 0x15 0x40.
    issue(4'hB, 4'd0, 7'd21, 7'd64, 1'b0, nb, f1);
    wait_ready(nb, 0);
    repeat (3) @(negedge clk);

    // Back-to-back with message_valid held.
    issue(4'h9, 4'd3, 7'd60, 7'd100, 1'b1, nb1, f1);
    message = {4'h8, 7'd60, 7'd0};
    wait_ready(nb1, 0);
    issue(4'h8, 4'd3, 7'd60, 7'd0, 1'b0, nb2, f2);
    check("b2b_gap", 32'(f2 - f1), 32'(nb1 * 10 * C + 1));
    wait_ready(nb2, 0);
    repeat (2) @(negedge clk);

    // message_valid pulse during byte 1 is ignored.
    issue(4'hE, 4'd5, 7'd1, 7'd2, 1'b0, nb, f1);
    repeat (150) @(negedge clk);
    message = {4'h9, 7'h7F, 7'h7F};
    message_valid = 1'b1;
    repeat (3) @(negedge clk);
    message_valid = 1'b0;
    check("valid_while_busy", 32'(message_ready), 32'd0);
    wait_ready(nb, 153);
    repeat (2) @(negedge clk);

    // Reset 55 cycles into a frame.
    issue(4'hA, 4'd7, 7'd11, 7'd22, 1'b0, nb, f1);
    repeat (54) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_ready", 32'(message_ready), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    rs_valid = 1'b0;
    reset = 1'b0;
    repeat (120) @(negedge clk);
    issue(4'hC, 4'd5, 7'd9, 7'd0, 1'b0, nb, f1);
    wait_ready(nb, 0);
    repeat (2) @(negedge clk);

    // Reset and message_valid together: no accept.
    message = {4'h9, 7'd1, 7'd2};
    channel = 4'd1;
    message_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    message_valid = 1'b0;
    reset = 1'b0;
    rs_valid = 1'b0;
    check("rst_valid_ready", 32'(message_ready), 32'd1);
    check("rst_valid_tx", 32'(tx), 32'd1);
    @(negedge clk);
    check("rst_valid_no_accept", 32'(message_ready), 32'd1);

    // Running-status sequence.
    issue(4'h9, 4'd3, 7'd60, 7'd100, 1'b0, nb, f1);
    wait_ready(nb, 0);
    issue(4'h9, 4'd3, 7'd62, 7'd90, 1'b0, nb, f1);
    wait_ready(nb, 0);
    issue(4'hB, 4'd3, 7'd7, 7'd8, 1'b0, nb, f1);
    wait_ready(nb, 0);

    // Randomized messages, mixed gaps and held valid.
    prev_hold = 1'b0;
    prev_nb = 0;
    prev_fall = 0;
    for (int k = 0; k < 20; k++) begin
      mt = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h9;
      ch = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom);
      hold = (k < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(mt, ch, 7'($urandom), 7'($urandom), hold, nb, f1);
      if (prev_hold) check("rand_b2b_gap", 32'(f1 - prev_fall), 32'(prev_nb * 10 * C + 1));
      wait_ready(nb, 0);
      if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
      prev_hold = hold;
      prev_nb = nb;
      prev_fall = f1;
    end

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
